// File: rtl/hilo_acc_file_pkg.sv
// -----------------------------------------------------------------------------
// hilo_acc_file_pkg
//   Shared definitions for the HI/LO accumulator file: operation codes and
//   small decode helpers used by the top level and the accumulate stage.
// -----------------------------------------------------------------------------
package hilo_acc_file_pkg;

    typedef enum logic [2:0] {
        OP_WR   = 3'b000,   // HI <= hi_i, LO <= lo_i
        OP_WRHI = 3'b001,   // HI <= hi_i
        OP_WRLO = 3'b010,   // LO <= lo_i
        OP_MADD = 3'b011,   // {HI,LO} += {hi_i,lo_i}, two-stage
        OP_MSUB = 3'b100,   // {HI,LO} -= {hi_i,lo_i}, two-stage
        OP_CLR  = 3'b101    // {HI,LO} <= 0
    } hilo_op_e;

    // Ops that commit on the request edge.
    function automatic logic is_direct_op(input logic [2:0] op);
        return (op == OP_WR) || (op == OP_WRHI) || (op == OP_WRLO) || (op == OP_CLR);
    endfunction

    // Ops that go through the accumulate stage.
    function automatic logic is_accum_op(input logic [2:0] op);
        return (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_acc_file_stage.sv
// -----------------------------------------------------------------------------
// hilo_acc_stage
//   Stage-1 holding register for MADD/MSUB plus the 2*DATA_W adder/subtractor.
//   The operand, target index and direction are captured on a load; on the
//   following cycle result_o = acc_i +/- operand, where acc_i is the pair
//   currently stored at idx_o (supplied by the top). Write priority against
//   direct ops is resolved by the top.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset, empties the stage
//   load_i    capture a new accumulate request
//   sub_i     1 = MSUB, 0 = MADD
//   idx_i     target pair index of the request
//   opnd_i    {hi_i, lo_i} operand
//   acc_i     stored {HI,LO} of pair idx_o
//   valid_o   stage occupied
//   idx_o     target pair of the held request
//   result_o  acc_i +/- held operand, modulo 2^(2*DATA_W)
// -----------------------------------------------------------------------------
module hilo_acc_stage #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                sub_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [2*DATA_W-1:0] opnd_i,
    input  logic [2*DATA_W-1:0] acc_i,
    output logic                valid_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic [2*DATA_W-1:0] result_o
);

    logic                valid_q, valid_d;
    logic                sub_q,   sub_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [2*DATA_W-1:0] opnd_q,  opnd_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        valid_d = load_i;
        sub_d   = sub_q;
        idx_d   = idx_q;
        opnd_d  = opnd_q;
        if (load_i) begin
            sub_d  = sub_i;
            idx_d  = idx_i;
            opnd_d = opnd_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: the payload is not reset; valid_q alone decides whether it is used.
    always_ff @(posedge clk) begin
        sub_q  <= sub_d;
        idx_q  <= idx_d;
        opnd_q <= opnd_d;
    end

    assign valid_o  = valid_q;
    assign idx_o    = idx_q;
    assign result_o = sub_q ? (acc_i - opnd_q) : (acc_i + opnd_q);

endmodule

// File: rtl/hilo_acc_file.sv
// -----------------------------------------------------------------------------
// hilo_acc_file
//   File of NUM_ACC HI/LO accumulator pairs. Supports whole-pair, HI-only and
//   LO-only writes, clear, and two-stage MADD/MSUB into a selected pair.
//   Reads are combinational from stored state; pend_o tells the reader that
//   an accumulate to the selected pair has not landed yet (no forwarding).
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   we      request valid
//   op      operation code (hilo_op_e)
//   wsel    target pair index
//   hi_i    HI operand / write data
//   lo_i    LO operand / write data
//   rsel    read pair index
//   hi_o    HI of pair rsel (0 when rsel out of range)
//   lo_o    LO of pair rsel (0 when rsel out of range)
//   pend_o  accumulate in flight targeting rsel
//   busy_o  accumulate stage occupied
// -----------------------------------------------------------------------------
module hilo_acc_file
    import hilo_acc_file_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int NUM_ACC = 4,
    localparam int IDX_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [2:0]        op,
    input  logic [IDX_W-1:0]  wsel,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic [IDX_W-1:0]  rsel,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              pend_o,
    output logic              busy_o
);

    logic [DATA_W-1:0] hi_q [NUM_ACC];
    logic [DATA_W-1:0] lo_q [NUM_ACC];
    logic [DATA_W-1:0] hi_d [NUM_ACC];
    logic [DATA_W-1:0] lo_d [NUM_ACC];

    logic                wsel_ok;
    logic                direct_req;
    logic                accum_req;
    logic                stg_valid;
    logic [IDX_W-1:0]    stg_idx;
    logic [2*DATA_W-1:0] stg_acc;
    logic [2*DATA_W-1:0] stg_result;

    // Out-of-range indices exist when NUM_ACC is not a power of two; such
    // requests are dropped before they reach storage or the stage.
    assign wsel_ok    = int'(wsel) < NUM_ACC;
    assign direct_req = we && wsel_ok && is_direct_op(op);
    assign accum_req  = we && wsel_ok && is_accum_op(op);

    // Old pair value for the held accumulate: always committed state, which
    // is what makes back-to-back accumulates to one pair chain correctly.
    always_comb begin
        stg_acc = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (int'(stg_idx) == i) stg_acc = {hi_q[i], lo_q[i]};
        end
    end

    hilo_acc_stage #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accum_req),
        .sub_i    (op == OP_MSUB),
        .idx_i    (wsel),
        .opnd_i   ({hi_i, lo_i}),
        .acc_i    (stg_acc),
        .valid_o  (stg_valid),
        .idx_o    (stg_idx),
        .result_o (stg_result)
    );

    // Write priority per pair: a direct op to the same pair is younger than
    // the held accumulate, so it wins and the accumulate is dropped; the
    // half a WRHI/WRLO does not touch keeps its pre-edge value.
    always_comb begin
        for (int i = 0; i < NUM_ACC; i++) begin
            hi_d[i] = hi_q[i];
            lo_d[i] = lo_q[i];
            if (direct_req && int'(wsel) == i) begin
                case (hilo_op_e'(op))
                    OP_WR: begin
                        hi_d[i] = hi_i;
                        lo_d[i] = lo_i;
                    end
                    OP_WRHI: hi_d[i] = hi_i;
                    OP_WRLO: lo_d[i] = lo_i;
                    OP_CLR: begin
                        hi_d[i] = '0;
                        lo_d[i] = '0;
                    end
                    default: ;
                endcase
            end else if (stg_valid && int'(stg_idx) == i) begin
                {hi_d[i], lo_d[i]} = stg_result;
            end
        end
    end

    // NOTE: the pair array is architectural state that must read 0 after
    // reset, so unlike a plain RAM every entry is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ACC; i++) begin
            if (rst) begin
                hi_q[i] <= '0;
                lo_q[i] <= '0;
            end else begin
                hi_q[i] <= hi_d[i];
                lo_q[i] <= lo_d[i];
            end
        end
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (int'(rsel) == i) begin
                hi_o = hi_q[i];
                lo_o = lo_q[i];
            end
        end
    end

    // stg_idx is always in range, so an out-of-range rsel never matches.
    assign busy_o = stg_valid;
    assign pend_o = stg_valid && (stg_idx == rsel);

endmodule
